// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_e;

    // Requester identifiers
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Contested CPU wins allowed before the DMA port is forced through
    localparam int STARVE_MAX_DEFAULT = 4;

    // Word accesses only: any nonzero low address bit is an alignment error
    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return lowBits != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arb_fairness.sv
// Winner selection between the CPU and DMA ports with a bounded-starvation
// counter. The CPU is preferred, but after STARVE_MAX contested CPU wins the
// DMA port takes the next grant.
module dmem_arb_fairness
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req_i,
    input  logic dma_req_i,
    input  logic grant_en_i,
    output logic winner_o
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          contested;
    logic          starveLimit;

    assign contested   = cpu_req_i & dma_req_i;
    assign starveLimit = (starve_q >= CW'(STARVE_MAX));

    // Pick the winner: CPU alone, or CPU in a contest while under the limit
    always_comb begin
        winner_o = PORT_CPU;
        if (dma_req_i && !(cpu_req_i && !starveLimit)) begin
            winner_o = PORT_DMA;
        end
    end

    // Count contested CPU wins, saturating, and clear on every DMA grant
    always_comb begin
        starve_d = starve_q;
        if (grant_en_i) begin
            if (winner_o == PORT_DMA) begin
                starve_d = '0;
            end else if (contested && !starveLimit) begin
                starve_d = starve_q + CW'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory.
// Each access runs IDLE -> ACCESS -> RESP (or IDLE -> ERR for misaligned
// addresses); the acknowledge and read data are registered and appear in the
// cycle after the FSM leaves RESP/ERR, while the FSM is already back in IDLE
// and can accept the next request.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_err,
    output logic [DW-1:0] rdata,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [AW-1:0] Addr,
    output logic [DW-1:0] Data_i,
    input  logic [DW-1:0] Data,
    output logic          gnt_dma,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic          cpu_err_q, cpu_err_d;
    logic          dma_err_q, dma_err_d;

    logic          grantEn;
    logic          winner;
    logic          selWe;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selWdata;

    dmem_arb_fairness #(
        .STARVE_MAX(STARVE_MAX)
    ) u_fairness (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req_i (cpu_req),
        .dma_req_i (dma_req),
        .grant_en_i(grantEn),
        .winner_o  (winner)
    );

    // Route the winning port's payload towards the IDLE latches
    always_comb begin
        selWe    = cpu_we;
        selAddr  = cpu_addr;
        selWdata = cpu_wdata;
        if (winner == PORT_DMA) begin
            selWe    = dma_we;
            selAddr  = dma_addr;
            selWdata = dma_wdata;
        end
    end

    // FSM next state, payload latching, read capture and ack/err generation
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        cpu_err_d = 1'b0;
        dma_err_d = 1'b0;
        grantEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grantEn = 1'b1;
                    owner_d = winner;
                    we_d    = selWe;
                    addr_d  = selAddr;
                    wdata_d = selWdata;
                    state_d = isMisaligned(selAddr[1:0]) ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (!we_q) begin
                    rdata_d = Data;
                end
                cpu_ack_d = (owner_q == PORT_CPU);
                dma_ack_d = (owner_q == PORT_DMA);
                state_d   = IDLE;
            end
            ERR: begin
                cpu_ack_d = (owner_q == PORT_CPU);
                dma_ack_d = (owner_q == PORT_DMA);
                cpu_err_d = (owner_q == PORT_CPU);
                dma_err_d = (owner_q == PORT_DMA);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched payload and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= PORT_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cpu_ack_q <= cpu_ack_d;
            dma_ack_q <= dma_ack_d;
            cpu_err_q <= cpu_err_d;
            dma_err_q <= dma_err_d;
        end
    end

    // Strobes decode straight from the state so reset drops them at once
    always_comb begin
        ReadMem  = (state_q == ACCESS) && !we_q;
        WriteMem = (state_q == ACCESS) && we_q;
        busy     = (state_q != IDLE);
        gnt_dma  = (state_q != IDLE) && (owner_q == PORT_DMA);
    end

    assign Addr    = addr_q;
    assign Data_i  = wdata_q;
    assign rdata   = rdata_q;
    assign cpu_ack = cpu_ack_q;
    assign dma_ack = dma_ack_q;
    assign cpu_err = cpu_err_q;
    assign dma_err = dma_err_q;

endmodule
